vrf_operand_collector: RTL and testbench

- In-order operand collector directly downstream of the vector register file read stage.
- Reserves one entry per issued uop. Gathers the per-port VFULEN-wide read fields that the VRF returns over one or more cycles, in any order and spread across cycles by bank conflicts and write-conflict stalls.
- Presents the fully assembled operand set to the vector FU through a valid/ready handshake.
- The VRF serves one read packet at a time, so every response belongs to the oldest incomplete entry.

---
 rtl/vrf_operand_collector.sv | 145 ++++++++++++++
 tb/tb_vrf_operand_collector.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_operand_collector.sv
// In-order operand collector behind the VRF read stage.
// Gathers per-field read responses per uop and hands complete sets to the FU.
module vrf_operand_collector #(
  parameter int VFULEN    = 64,
  parameter int NUM_RS    = 3,
  parameter int FIELD_NUM = 2,
  parameter int RPORT_NUM = 4,
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 6
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  flush,
  input  logic                                  alloc_vld,
  output logic                                  alloc_rdy,
  input  logic [TAG_WIDTH-1:0]                  alloc_tag,
  input  logic [NUM_RS*FIELD_NUM-1:0]           alloc_need,
  input  logic [RPORT_NUM-1:0]                  rsp_vld,
  input  logic [RPORT_NUM*2-1:0]                rsp_rs_idx,
  input  logic [RPORT_NUM-1:0]                  rsp_field_idx,
  input  logic [RPORT_NUM*VFULEN-1:0]           rsp_data,
  output logic                                  fu_vld,
  input  logic                                  fu_rdy,
  output logic [TAG_WIDTH-1:0]                  fu_tag,
  output logic [NUM_RS*FIELD_NUM-1:0]           fu_need,
  output logic [NUM_RS*FIELD_NUM*VFULEN-1:0]    fu_opnd,
  output logic [$clog2(DEPTH+1)-1:0]            count,
  output logic                                  err
);

  localparam int NF = NUM_RS * FIELD_NUM;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]       r_vld;
  logic [TAG_WIDTH-1:0]   r_tag  [DEPTH];
  logic [NF-1:0]          r_need [DEPTH];
  logic [NF-1:0]          r_got  [DEPTH];
  logic [NF*VFULEN-1:0]   r_data [DEPTH];
  logic [PW-1:0]          r_head, r_tail, r_fill;
  logic [CW-1:0]          r_count;
  logic                   r_err;

  logic                   w_fill_open, w_fill_done;
  logic                   w_alloc, w_deq;
  logic [NF-1:0]          w_wr_mask;
  logic [NF*VFULEN-1:0]   w_wr_data;
  logic                   w_rsp_err;

  assign w_fill_open = r_vld[r_fill] & (r_got[r_fill] != r_need[r_fill]);
  assign w_fill_done = r_vld[r_fill] & (r_got[r_fill] == r_need[r_fill]);

  assign alloc_rdy = (r_count < CW'(DEPTH)) & ~flush;
  assign fu_vld    = r_vld[r_head] & (r_got[r_head] == r_need[r_head]);
  assign fu_tag    = r_tag[r_head];
  assign fu_need   = r_need[r_head];
  assign fu_opnd   = r_data[r_head];
  assign count     = r_count;
  assign err       = r_err;

  assign w_alloc = alloc_vld & alloc_rdy;
  assign w_deq   = fu_vld & fu_rdy;

  // Ascending port order lets the highest port win a same-field collision.
  always_comb begin
    int rs;
    int fi;
    int f;
    rs        = 0;
    fi        = 0;
    f         = 0;
    w_wr_mask = '0;
    w_wr_data = '0;
    w_rsp_err = 1'b0;
    for (int p = 0; p < RPORT_NUM; p++) begin
      if (rsp_vld[p]) begin
        rs = int'(rsp_rs_idx[2*p +: 2]);
        fi = int'(rsp_field_idx[p]);
        f  = rs * FIELD_NUM + fi;
        if (!w_fill_open || rs >= NUM_RS) begin
          w_rsp_err = 1'b1;
        end else if (!r_need[r_fill][f] || r_got[r_fill][f]) begin
          w_rsp_err = 1'b1;
        end else begin
          if (w_wr_mask[f]) w_rsp_err = 1'b1;
          w_wr_mask[f] = 1'b1;
          w_wr_data[f*VFULEN +: VFULEN] = rsp_data[p*VFULEN +: VFULEN];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_fill  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        r_tag[e]  <= '0;
        r_need[e] <= '0;
        r_got[e]  <= '0;
        r_data[e] <= '0;
      end
    end else if (flush) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_fill  <= '0;
      r_count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        r_tag[e]  <= '0;
        r_need[e] <= '0;
        r_got[e]  <= '0;
        r_data[e] <= '0;
      end
    end else begin
      if (w_rsp_err) r_err <= 1'b1;
      if (w_fill_done) r_fill <= r_fill + 1'b1;
      if (|w_wr_mask) begin
        r_got[r_fill] <= r_got[r_fill] | w_wr_mask;
        for (int f = 0; f < NF; f++) begin
          if (w_wr_mask[f])
            r_data[r_fill][f*VFULEN +: VFULEN] <= w_wr_data[f*VFULEN +: VFULEN];
        end
      end
      if (w_deq) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_vld[r_tail]  <= 1'b1;
        r_tag[r_tail]  <= alloc_tag;
        r_need[r_tail] <= alloc_need;
        r_got[r_tail]  <= '0;
        r_data[r_tail] <= '0;
        r_tail         <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_deq);
    end
  end

endmodule

// File: tb/tb_vrf_operand_collector.sv
// Directed bench for vrf_operand_collector.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_vrf_operand_collector;

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush;
  logic         alloc_vld;
  logic         alloc_rdy;
  logic [5:0]   alloc_tag;
  logic [5:0]   alloc_need;
  logic [3:0]   rsp_vld;
  logic [7:0]   rsp_rs_idx;
  logic [3:0]   rsp_field_idx;
  logic [255:0] rsp_data;
  logic         fu_vld;
  logic         fu_rdy;
  logic [5:0]   fu_tag;
  logic [5:0]   fu_need;
  logic [383:0] fu_opnd;
  logic [2:0]   count;
  logic         err;

  int n_chk = 0;
  int n_err = 0;
  logic [383:0] e;

  vrf_operand_collector dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy),
    .alloc_tag(alloc_tag), .alloc_need(alloc_need),
    .rsp_vld(rsp_vld), .rsp_rs_idx(rsp_rs_idx),
    .rsp_field_idx(rsp_field_idx), .rsp_data(rsp_data),
    .fu_vld(fu_vld), .fu_rdy(fu_rdy), .fu_tag(fu_tag),
    .fu_need(fu_need), .fu_opnd(fu_opnd),
    .count(count), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [383:0] obs,
                     input logic [383:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush     = 1'b0;
    alloc_vld = 1'b0;
    fu_rdy    = 1'b0;
    rsp_vld   = '0;
    rsp_rs_idx = '0;
    rsp_field_idx = '0;
    rsp_data  = '0;
  endtask

  task automatic rsp(input int p, input logic [1:0] rs,
                     input logic fi, input logic [63:0] d);
    rsp_vld[p]            = 1'b1;
    rsp_rs_idx[2*p +: 2]  = rs;
    rsp_field_idx[p]      = fi;
    rsp_data[p*64 +: 64]  = d;
  endtask

  task automatic alloc(input logic [5:0] tag, input logic [5:0] need);
    alloc_vld  = 1'b1;
    alloc_tag  = tag;
    alloc_need = need;
  endtask

  initial begin
    rstn = 1'b0;
    alloc_tag = '0;
    alloc_need = '0;
    idle();
    step();
    step();
    chk("rst_count", 384'(count), 384'(0));
    chk("rst_rdy", 384'(alloc_rdy), 384'(1));
    chk("rst_fu_vld", 384'(fu_vld), 384'(0));
    chk("rst_fu_tag", 384'(fu_tag), 384'(0));
    chk("rst_fu_need", 384'(fu_need), 384'(0));
    chk("rst_fu_opnd", fu_opnd, 384'(0));
    chk("rst_err", 384'(err), 384'(0));
    rstn = 1'b1;
    step();

    // Basic two-field gather with a gap between responses
    alloc(6'd5, 6'b000011);
    step(); idle();
    chk("t1_count", 384'(count), 384'(1));
    rsp(0, 2'd0, 1'b0, 64'hA);
    step(); idle();
    chk("t1_partial", 384'(fu_vld), 384'(0));
    step();
    rsp(2, 2'd0, 1'b1, 64'hB);
    step(); idle();
    chk("t1_vld", 384'(fu_vld), 384'(1));
    chk("t1_tag", 384'(fu_tag), 384'(5));
    chk("t1_need", 384'(fu_need), 384'(3));
    e = '0; e[63:0] = 64'hA; e[127:64] = 64'hB;
    chk("t1_opnd", fu_opnd, e);
    fu_rdy = 1'b1;
    step(); idle();
    chk("t1_deq_vld", 384'(fu_vld), 384'(0));
    chk("t1_deq_cnt", 384'(count), 384'(0));

    // Fill to capacity
    for (int i = 1; i <= 4; i++) begin
      alloc(6'(i), 6'b000001);
      step();
    end
    idle();
    chk("t2_full_cnt", 384'(count), 384'(4));
    chk("t2_full_rdy", 384'(alloc_rdy), 384'(0));
    alloc(6'd7, 6'b000001);
    step(); idle();
    chk("t2_5th_cnt", 384'(count), 384'(4));
    chk("t2_head_tag", 384'(fu_tag), 384'(1));
    rsp(0, 2'd0, 1'b0, 64'h11);
    step(); idle();
    chk("t2_h1_vld", 384'(fu_vld), 384'(1));
    // Full collector: dequeue does not open a slot the same cycle
    alloc(6'd7, 6'b000001);
    fu_rdy = 1'b1;
    #1 chk("t2_nobypass", 384'(alloc_rdy), 384'(0));
    step(); idle();
    chk("t2_after_cnt", 384'(count), 384'(3));
    chk("t2_tag2", 384'(fu_tag), 384'(2));
    rsp(1, 2'd0, 1'b0, 64'h22);
    step(); idle();
    chk("t2_h2_vld", 384'(fu_vld), 384'(1));
    alloc(6'd8, 6'b000001);
    fu_rdy = 1'b1;
    step(); idle();
    chk("t2_ad_cnt", 384'(count), 384'(3));
    chk("t2_tag3", 384'(fu_tag), 384'(3));
    rsp(0, 2'd0, 1'b0, 64'h33);
    step(); idle();
    chk("t2_h3_vld", 384'(fu_vld), 384'(1));
    step();
    // Dequeue tag3 while tag4 collects
    fu_rdy = 1'b1;
    rsp(0, 2'd0, 1'b0, 64'h44);
    step(); idle();
    chk("t2_both_cnt", 384'(count), 384'(2));
    chk("t2_h4_vld", 384'(fu_vld), 384'(1));
    chk("t2_h4_tag", 384'(fu_tag), 384'(4));
    e = '0; e[63:0] = 64'h44;
    chk("t2_h4_opnd", fu_opnd, e);
    fu_rdy = 1'b1;
    step(); idle();
    rsp(0, 2'd0, 1'b0, 64'h88);
    step(); idle();
    chk("t2_h8_tag", 384'(fu_tag), 384'(8));
    chk("t2_h8_vld", 384'(fu_vld), 384'(1));
    fu_rdy = 1'b1;
    step(); idle();
    chk("t2_empty", 384'(count), 384'(0));
    chk("t2_err", 384'(err), 384'(0));

    // Six fields over two cycles, then a second uop
    alloc(6'd10, 6'b111111);
    step();
    alloc(6'd11, 6'b000001);
    step(); idle();
    rsp(0, 2'd0, 1'b0, 64'hA0);
    rsp(1, 2'd0, 1'b1, 64'hA1);
    rsp(2, 2'd1, 1'b0, 64'hA2);
    rsp(3, 2'd1, 1'b1, 64'hA3);
    step(); idle();
    chk("t3_a_partial", 384'(fu_vld), 384'(0));
    rsp(0, 2'd2, 1'b0, 64'hA4);
    rsp(1, 2'd2, 1'b1, 64'hA5);
    step(); idle();
    chk("t3_a_vld", 384'(fu_vld), 384'(1));
    chk("t3_a_tag", 384'(fu_tag), 384'(10));
    e = {64'hA5, 64'hA4, 64'hA3, 64'hA2, 64'hA1, 64'hA0};
    chk("t3_a_opnd", fu_opnd, e);
    fu_rdy = 1'b1;
    step(); idle();
    chk("t3_b_tag", 384'(fu_tag), 384'(11));
    chk("t3_b_wait", 384'(fu_vld), 384'(0));
    rsp(3, 2'd0, 1'b0, 64'hB0);
    step(); idle();
    chk("t3_b_vld", 384'(fu_vld), 384'(1));
    e = '0; e[63:0] = 64'hB0;
    chk("t3_b_opnd", fu_opnd, e);
    fu_rdy = 1'b1;
    step(); idle();
    chk("t3_cnt", 384'(count), 384'(0));
    chk("t3_err", 384'(err), 384'(0));

    // Empty need mask completes immediately
    alloc(6'd12, 6'b000000);
    step(); idle();
    chk("t4_vld", 384'(fu_vld), 384'(1));
    chk("t4_tag", 384'(fu_tag), 384'(12));
    fu_rdy = 1'b1;
    step(); idle();
    chk("t4_cnt", 384'(count), 384'(0));
    chk("t4_err", 384'(err), 384'(0));

    // Protocol errors
    alloc(6'd13, 6'b000101);
    step(); idle();
    rsp(0, 2'd0, 1'b0, 64'h55);
    step(); idle();
    chk("t5_ok_err", 384'(err), 384'(0));
    rsp(0, 2'd0, 1'b1, 64'h66);
    step(); idle();
    chk("t5_unreq_err", 384'(err), 384'(1));
    rsp(1, 2'd0, 1'b0, 64'h77);
    step(); idle();
    chk("t5_dup_err", 384'(err), 384'(1));
    chk("t5_dup_vld", 384'(fu_vld), 384'(0));
    rsp(0, 2'd1, 1'b0, 64'h99);
    step(); idle();
    chk("t5_vld", 384'(fu_vld), 384'(1));
    e = '0; e[63:0] = 64'h55; e[191:128] = 64'h99;
    chk("t5_opnd", fu_opnd, e);
    fu_rdy = 1'b1;
    step(); idle();
    rsp(0, 2'd0, 1'b0, 64'hEE);
    step(); idle();
    chk("t5_empty_err", 384'(err), 384'(1));
    chk("t5_empty_cnt", 384'(count), 384'(0));

    // Flush with entries in flight
    alloc(6'd20, 6'b000011);
    step();
    alloc(6'd21, 6'b000011);
    step();
    alloc(6'd22, 6'b000011);
    step(); idle();
    rsp(0, 2'd0, 1'b0, 64'h20);
    step(); idle();
    chk("t6_pre_cnt", 384'(count), 384'(3));
    flush = 1'b1;
    #1 chk("t6_flush_rdy", 384'(alloc_rdy), 384'(0));
    step(); idle();
    chk("t6_cnt", 384'(count), 384'(0));
    chk("t6_vld", 384'(fu_vld), 384'(0));
    chk("t6_err_kept", 384'(err), 384'(1));
    alloc(6'd9, 6'b000001);
    step(); idle();
    rsp(0, 2'd0, 1'b0, 64'h9);
    step(); idle();
    chk("t6_9_vld", 384'(fu_vld), 384'(1));
    chk("t6_9_tag", 384'(fu_tag), 384'(9));
    e = '0; e[63:0] = 64'h9;
    chk("t6_9_opnd", fu_opnd, e);
    fu_rdy = 1'b1;
    step(); idle();

    // Asynchronous reset mid-collection
    alloc(6'd30, 6'b000011);
    step();
    alloc(6'd31, 6'b000011);
    step(); idle();
    rsp(0, 2'd0, 1'b0, 64'h30);
    rsp(1, 2'd0, 1'b1, 64'h31);
    step(); idle();
    rsp(0, 2'd0, 1'b0, 64'h3A);
    #1 chk("t7_pre_vld", 384'(fu_vld), 384'(1));
    #1 rstn = 1'b0;
    #1;
    chk("t7_vld", 384'(fu_vld), 384'(0));
    chk("t7_cnt", 384'(count), 384'(0));
    chk("t7_tag", 384'(fu_tag), 384'(0));
    chk("t7_opnd", fu_opnd, 384'(0));
    chk("t7_err", 384'(err), 384'(0));
    chk("t7_rdy", 384'(alloc_rdy), 384'(1));
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
